// File: rtl/jtag_pkg.sv
// Shared TAP types: state encoding, default opcodes and the next-state function.
package jtag_pkg;

  localparam int unsigned IDCODE_W      = 32;
  localparam int unsigned DEF_OP_SAMPLE = 1;
  localparam int unsigned DEF_OP_IDCODE = 2;

  // Classic 1149.1 reference encoding, so tap_state reads like a datasheet trace.
  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0,
    EXIT1_DR   = 4'h1,
    SHIFT_DR   = 4'h2,
    PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4,
    UPDATE_DR  = 4'h5,
    CAPTURE_DR = 4'h6,
    SELECT_DR  = 4'h7,
    EXIT2_IR   = 4'h8,
    EXIT1_IR   = 4'h9,
    SHIFT_IR   = 4'hA,
    PAUSE_IR   = 4'hB,
    RUN_IDLE   = 4'hC,
    UPDATE_IR  = 4'hD,
    CAPTURE_IR = 4'hE,
    TEST_RESET = 4'hF
  } tap_state_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TEST_RESET;
    case (s)
      TEST_RESET: n = tms ? TEST_RESET : RUN_IDLE;
      RUN_IDLE:   n = tms ? SELECT_DR  : RUN_IDLE;
      SELECT_DR:  n = tms ? SELECT_IR  : CAPTURE_DR;
      CAPTURE_DR: n = tms ? EXIT1_DR   : SHIFT_DR;
      SHIFT_DR:   n = tms ? EXIT1_DR   : SHIFT_DR;
      EXIT1_DR:   n = tms ? UPDATE_DR  : PAUSE_DR;
      PAUSE_DR:   n = tms ? EXIT2_DR   : PAUSE_DR;
      EXIT2_DR:   n = tms ? UPDATE_DR  : SHIFT_DR;
      UPDATE_DR:  n = tms ? SELECT_DR  : RUN_IDLE;
      SELECT_IR:  n = tms ? TEST_RESET : CAPTURE_IR;
      CAPTURE_IR: n = tms ? EXIT1_IR   : SHIFT_IR;
      SHIFT_IR:   n = tms ? EXIT1_IR   : SHIFT_IR;
      EXIT1_IR:   n = tms ? UPDATE_IR  : PAUSE_IR;
      PAUSE_IR:   n = tms ? EXIT2_IR   : PAUSE_IR;
      EXIT2_IR:   n = tms ? UPDATE_IR  : SHIFT_IR;
      UPDATE_IR:  n = tms ? SELECT_DR  : RUN_IDLE;
      default:    n = TEST_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller with registered per-state decode flags.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  output tap_state_t state_o,
  output logic       tlr_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o
);

  tap_state_t state_q, state_d;

  always_comb begin
    state_d = tap_next(state_q, tms_i);
  end

  // Flags are registered from state_d so they are aligned with state_q and glitch-free.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q      <= TEST_RESET;
      tlr_o        <= 1'b1;
      capture_dr_o <= 1'b0;
      shift_dr_o   <= 1'b0;
      update_dr_o  <= 1'b0;
      capture_ir_o <= 1'b0;
      shift_ir_o   <= 1'b0;
      update_ir_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tlr_o        <= (state_d == TEST_RESET);
      capture_dr_o <= (state_d == CAPTURE_DR);
      shift_dr_o   <= (state_d == SHIFT_DR);
      update_dr_o  <= (state_d == UPDATE_DR);
      capture_ir_o <= (state_d == CAPTURE_IR);
      shift_ir_o   <= (state_d == SHIFT_IR);
      update_ir_o  <= (state_d == UPDATE_IR);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_param.sv
// TAP top: instruction register, BYPASS/IDCODE data registers, decode and TDO mux.
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_LEN    = 4,
  parameter logic [IDCODE_W-1:0]  IDCODE    = 32'h1000_0765,
  parameter logic [IR_LEN-1:0]    OP_EXTEST = '0,
  parameter logic [IR_LEN-1:0]    OP_SAMPLE = IR_LEN'(DEF_OP_SAMPLE),
  parameter logic [IR_LEN-1:0]    OP_IDCODE = IR_LEN'(DEF_OP_IDCODE)
) (
  input  logic              TCLK,
  input  logic              TRST,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  output logic              tdo_en,
  input  logic              bsr_tdo,
  output logic              bsr_capture,
  output logic              bsr_shift,
  output logic              bsr_update,
  output logic              extest,
  output logic [IR_LEN-1:0] ir_q,
  output logic [3:0]        tap_state
);

  localparam logic [IR_LEN-1:0] OP_BYPASS  = '1;
  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(2'b01);

  if (IR_LEN < 2) begin : g_chk_len
    $error("jtag_tap_param: IR_LEN must be at least 2");
  end
  if (OP_EXTEST == OP_SAMPLE || OP_EXTEST == OP_IDCODE || OP_SAMPLE == OP_IDCODE ||
      OP_EXTEST == OP_BYPASS || OP_SAMPLE == OP_BYPASS || OP_IDCODE == OP_BYPASS) begin : g_chk_op
    $error("jtag_tap_param: opcodes must be distinct");
  end
  if (IDCODE[0] != 1'b1) begin : g_chk_id
    $error("jtag_tap_param: IDCODE bit 0 must be 1");
  end

  tap_state_t          state;
  logic                tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;
  logic [IR_LEN-1:0]   ir_sr_q;
  logic                bypass_q;
  logic [IDCODE_W-1:0] idcode_q;
  logic                sel_bsr, sel_id;

  jtag_tap_fsm u_fsm (
    .tck_i        (TCLK),
    .trst_ni      (TRST),
    .tms_i        (TMS),
    .state_o      (state),
    .tlr_o        (tlr),
    .capture_dr_o (cap_dr),
    .shift_dr_o   (sh_dr),
    .update_dr_o  (upd_dr),
    .capture_ir_o (cap_ir),
    .shift_ir_o   (sh_ir),
    .update_ir_o  (upd_ir)
  );

  assign sel_bsr = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);
  assign sel_id  = (ir_q == OP_IDCODE);

  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      ir_sr_q <= '0;
      ir_q    <= OP_IDCODE;
    end else begin
      if (cap_ir) begin
        ir_sr_q <= IR_CAPTURE;
      end else if (sh_ir) begin
        ir_sr_q <= {TDI, ir_sr_q[IR_LEN-1:1]};
      end
      if (tlr) begin
        ir_q <= OP_IDCODE;
      end else if (upd_ir) begin
        ir_q <= ir_sr_q;
      end
    end
  end

  // BYPASS bit runs for every instruction; it is only observed when no other DR is selected.
  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      bypass_q <= 1'b0;
      idcode_q <= IDCODE;
    end else begin
      if (cap_dr) begin
        bypass_q <= 1'b0;
        if (sel_id) idcode_q <= IDCODE;
      end else if (sh_dr) begin
        bypass_q <= TDI;
        if (sel_id) idcode_q <= {TDI, idcode_q[IDCODE_W-1:1]};
      end
    end
  end

  always_comb begin
    TDO = 1'b0;
    if (TRST) begin
      if (sh_ir)        TDO = ir_sr_q[0];
      else if (sel_bsr) TDO = bsr_tdo;
      else if (sel_id)  TDO = idcode_q[0];
      else              TDO = bypass_q;
    end
  end

  assign tdo_en      = sh_dr | sh_ir;
  assign bsr_capture = cap_dr & sel_bsr;
  assign bsr_shift   = sh_dr  & sel_bsr;
  assign bsr_update  = upd_dr & sel_bsr;
  assign extest      = (ir_q == OP_EXTEST);
  assign tap_state   = state;

endmodule
